uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single RS232C byte transmitter between two requesters: the CPU output path (OUTPUTB byte pushes) and the debug/monitor dump path. Each requester writes into its own small FIFO; a round-robin scheduler drains them one byte at a time into the transmitter using a start/busy handshake. Sits between instruction dispatch/debug logic and the serial TX core.

## Interface
- `DEPTH`, 16: entries per requester FIFO; power of two, 2..256.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cpu_push`  in  1  CPU byte valid; one byte per asserted cycle.
- `cpu_data`  in  8  CPU byte.
- `cpu_full`  out  1  CPU FIFO holds DEPTH entries.
- `dbg_push`  in  1  debug byte valid.
- `dbg_data`  in  8  debug byte.
- `dbg_full`  out  1  debug FIFO holds DEPTH entries.
- `tx_busy`  in  1  transmitter serialising a byte.
- `tx_start`  out  1  one-cycle strobe: transmitter latches `tx_data`.
- `tx_data`  out  8  byte to send; stable from `tx_start` until return to IDLE.
- `idle`  out  1  both FIFOs empty and FSM in IDLE.

## Operation
- Reset values: `tx_start`=0, `tx_data`=0, `cpu_full`=`dbg_full`=0, `idle`=1; FIFOs empty; state IDLE; last-grant = DBG (CPU wins first tie).
- Push accepted when push=1 and FIFO not full at that edge. Push while full is dropped silently; a same-cycle pop does not rescue it (full sampled before pop).
- FIFO pointers are log2(DEPTH)+1 bits; wrap-around via MSB; full = MSB differ, rest equal.
- FSM states:
  - IDLE: if `tx_busy`=0 and ≥1 FIFO non-empty → grant (round-robin: if both non-empty, grant the one not granted last; else the non-empty one), pop head into `tx_data`, update last-grant, go START.
  - START: `tx_start`=1 for exactly this cycle → WAIT_BUSY.
  - WAIT_BUSY: stay until `tx_busy`=1 → WAIT_DONE.
  - WAIT_DONE: stay until `tx_busy`=0 → IDLE.
- No byte is issued while `tx_busy`=1 in IDLE.
- `idle` is registered: 1 iff state IDLE and both FIFOs empty after the edge.
- Reset mid-transfer: FSM, FIFOs and `tx_data` cleared immediately; in-flight transmitter byte is not recalled.

## Timing
- Push at edge N → FIFO non-empty after N; IDLE grants at edge N+1; `tx_start` high during cycle after N+1 (edge N+2 drops it). Push-to-start latency 2 cycles with transmitter idle.
- Minimum byte spacing: IDLE→START→WAIT_BUSY→WAIT_DONE→IDLE = 4 cycles plus transmitter busy time.
- `cpu_full`/`dbg_full` registered, valid the cycle after the filling push; deassert the cycle after the freeing pop.
- Simultaneous push and pop on non-full, non-empty FIFO: both take effect, count unchanged.

## Configuration
- `UART_ARB_DROP_CNT_EN`: when defined, adds outputs `cpu_drops` and `dbg_drops` (16 bits each), incremented on every dropped push, saturating at 0xFFFF, reset to 0. When undefined, the ports and counters do not exist; drop behaviour otherwise identical.

## Structure
- Package `uart_arb_pkg`: FSM state enum (IDLE, START, WAIT_BUSY, WAIT_DONE), grant enum (GRANT_CPU, GRANT_DBG), default DEPTH constant.
- Sub-module `uart_arb_fifo` (8-bit synchronous FIFO with push/pop/full/empty, parameter DEPTH), instantiated twice; arbiter FSM lives in the top.

## Test plan
- Reset, then CPU pushes 0x41 with `tx_busy`=0 → `tx_start` pulse 2 cycles later with `tx_data`=0x41; `idle` returns to 1 after model clears busy.
- Both FIFOs loaded (CPU 0x10,0x11; DBG 0x20,0x21) before first grant → transmit order 0x10,0x20,0x11,0x21.
- `tx_busy` held 1 for 50 cycles after `tx_start` → no second `tx_start` until busy falls; next byte follows 1 cycle after returning to IDLE.
- Push DEPTH+3 CPU bytes with transmitter stalled busy → `cpu_full`=1, last 3 dropped, (with `UART_ARB_DROP_CNT_EN`) `cpu_drops`=3; drained sequence equals first DEPTH bytes in order.
- Push on full FIFO in same cycle as pop → push dropped, count becomes DEPTH−1.
- Assert `rst_n`=0 during WAIT_DONE with both FIFOs non-empty → all outputs at reset values asynchronously; after release no `tx_start` without new pushes.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types for the UART TX arbiter: FSM states, grant owner, default FIFO depth.
// Optional build macro UART_ARB_DROP_CNT_EN is consumed by uart_tx_arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_e;

  typedef enum logic {
    GRANT_CPU = 1'b0,
    GRANT_DBG = 1'b1
  } grant_e;

  localparam int unsigned UART_ARB_DEPTH = 16;

endpackage

// File: rtl/uart_arb_fifo.sv
// 8-bit synchronous FIFO with wrap-bit pointers; full/empty are registered.
// A push while full is dropped even if a pop happens on the same edge.
module uart_arb_fifo
  import uart_arb_pkg::*;
#(
  parameter int unsigned DEPTH = UART_ARB_DEPTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty,
  output logic       empty_nxt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        full_q, full_d;
  logic        empty_q, empty_d;
  logic        push_ok, pop_ok;
  logic [7:0]  mem_q [DEPTH];

  always_comb begin
    push_ok  = push && !full_q;
    pop_ok   = pop && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    empty_d = (wr_ptr_d == rd_ptr_d);
    // Same index, opposite lap bit: writer is a whole lap ahead.
    full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
              (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  assign pop_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign full      = full_q;
  assign empty     = empty_q;
  assign empty_nxt = empty_d;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one byte transmitter between CPU and debug FIFOs.
// Define UART_ARB_DROP_CNT_EN to add saturating dropped-push counters.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned DEPTH = UART_ARB_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_push,
  input  logic [7:0]  cpu_data,
  output logic        cpu_full,
  input  logic        dbg_push,
  input  logic [7:0]  dbg_data,
  output logic        dbg_full,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        idle
`ifdef UART_ARB_DROP_CNT_EN
  ,
  output logic [15:0] cpu_drops,
  output logic [15:0] dbg_drops
`endif
);

  logic       cpu_pop, dbg_pop;
  logic [7:0] cpu_head, dbg_head;
  logic       cpu_empty, dbg_empty;
  logic       cpu_empty_nxt, dbg_empty_nxt;

  uart_arb_fifo #(.DEPTH(DEPTH)) u_cpu_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cpu_push),
    .push_data (cpu_data),
    .pop       (cpu_pop),
    .pop_data  (cpu_head),
    .full      (cpu_full),
    .empty     (cpu_empty),
    .empty_nxt (cpu_empty_nxt)
  );

  uart_arb_fifo #(.DEPTH(DEPTH)) u_dbg_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (dbg_push),
    .push_data (dbg_data),
    .pop       (dbg_pop),
    .pop_data  (dbg_head),
    .full      (dbg_full),
    .empty     (dbg_empty),
    .empty_nxt (dbg_empty_nxt)
  );

  arb_state_e state_q, state_d;
  grant_e     last_q, last_d;
  logic       tx_start_q, tx_start_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       idle_q, idle_d;

  always_comb begin
    cpu_pop = 1'b0;
    dbg_pop = 1'b0;
    // CPU wins when it is the only requester or the debug side had the last turn.
    if (state_q == IDLE && !tx_busy) begin
      if (!cpu_empty && (dbg_empty || last_q == GRANT_DBG)) cpu_pop = 1'b1;
      else if (!dbg_empty)                                  dbg_pop = 1'b1;
    end

    state_d = state_q;
    unique case (state_q)
      IDLE:      if (cpu_pop || dbg_pop) state_d = START;
      START:     state_d = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy)  state_d = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    tx_start_d = cpu_pop || dbg_pop;
    tx_data_d  = cpu_pop ? cpu_head : (dbg_pop ? dbg_head : tx_data_q);
    last_d     = cpu_pop ? GRANT_CPU : (dbg_pop ? GRANT_DBG : last_q);
    idle_d     = (state_d == IDLE) && cpu_empty_nxt && dbg_empty_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_q     <= GRANT_DBG;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      idle_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      idle_q     <= idle_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign idle     = idle_q;

`ifdef UART_ARB_DROP_CNT_EN
  logic [15:0] cpu_drops_q, cpu_drops_d;
  logic [15:0] dbg_drops_q, dbg_drops_d;

  always_comb begin
    cpu_drops_d = cpu_drops_q;
    dbg_drops_d = dbg_drops_q;
    if (cpu_push && cpu_full && cpu_drops_q != 16'hFFFF) cpu_drops_d = cpu_drops_q + 16'd1;
    if (dbg_push && dbg_full && dbg_drops_q != 16'hFFFF) dbg_drops_d = dbg_drops_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_drops_q <= 16'h0000;
      dbg_drops_q <= 16'h0000;
    end else begin
      cpu_drops_q <= cpu_drops_d;
      dbg_drops_q <= dbg_drops_d;
    end
  end

  assign cpu_drops = cpu_drops_q;
  assign dbg_drops = dbg_drops_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter with a queue-based round-robin model
// and a behavioural transmitter that answers tx_start with a busy window.
module tb_uart_tx_arbiter;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cpu_push = 1'b0, dbg_push = 1'b0;
  logic [7:0] cpu_data = 8'h00, dbg_data = 8'h00;
  logic       cpu_full, dbg_full, tx_start, idle, tx_busy;
  logic [7:0] tx_data;
`ifdef UART_ARB_DROP_CNT_EN
  logic [15:0] cpu_drops, dbg_drops;
`endif

  int checks = 0, failures = 0;
  bit force_busy = 1'b0, mdl_busy = 1'b0;
  int busy_len = 3, busy_cnt = 0, cyc = 0, bad_start = 0;
  logic [7:0] got[$];
  int         got_cyc[$];
  logic [7:0] m_cpu[$], m_dbg[$], exp_q[$];
  bit         m_last = 1'b1;  // 1 = debug granted last
  int         m_cpu_drops = 0, m_dbg_drops = 0;

  assign tx_busy = force_busy | mdl_busy;

  uart_tx_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_push(cpu_push), .cpu_data(cpu_data), .cpu_full(cpu_full),
    .dbg_push(dbg_push), .dbg_data(dbg_data), .dbg_full(dbg_full),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data), .idle(idle)
`ifdef UART_ARB_DROP_CNT_EN
    , .cpu_drops(cpu_drops), .dbg_drops(dbg_drops)
`endif
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Transmitter: latch on tx_start, stay busy for busy_len cycles.
  initial forever begin
    @(negedge clk);
    if (tx_start === 1'b1) begin
      if (tx_busy) bad_start++;
      got.push_back(tx_data);
      got_cyc.push_back(cyc);
      mdl_busy = 1'b1;
      busy_cnt = busy_len;
    end else if (mdl_busy) begin
      busy_cnt--;
      if (busy_cnt <= 0) mdl_busy = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_both(input bit dc, input logic [7:0] c, input bit dd, input logic [7:0] d);
    @(negedge clk);
    cpu_push = dc; cpu_data = c; dbg_push = dd; dbg_data = d;
    if (dc) begin if (m_cpu.size() < DEPTH) m_cpu.push_back(c); else m_cpu_drops++; end
    if (dd) begin if (m_dbg.size() < DEPTH) m_dbg.push_back(d); else m_dbg_drops++; end
  endtask

  // Expected transmit order from the round-robin rule applied to the model queues.
  task automatic calc_order();
    exp_q.delete();
    while (m_cpu.size() > 0 || m_dbg.size() > 0) begin
      if (m_cpu.size() > 0 && (m_dbg.size() == 0 || m_last)) begin
        exp_q.push_back(m_cpu.pop_front()); m_last = 1'b0;
      end else begin
        exp_q.push_back(m_dbg.pop_front()); m_last = 1'b1;
      end
    end
  endtask

  task automatic wait_caps(input int n, input int budget, output bit ok);
    ok = (got.size() >= n);
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      if (got.size() >= n) ok = 1'b1;
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      if (idle === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cpu_push = 1'b0; dbg_push = 1'b0; force_busy = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_cpu.delete(); m_dbg.delete(); got.delete(); got_cyc.delete();
    m_last = 1'b1; m_cpu_drops = 0; m_dbg_drops = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({tx_start, tx_data, cpu_full, dbg_full, idle} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_in: start/data/cf/df/idle=%b/%h/%b/%b/%b want 0/00/0/0/1",
               tx_start, tx_data, cpu_full, dbg_full, idle);
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b0 || idle !== 1'b1) begin
      failures++;
      $display("FAIL reset_out: start=%b idle=%b want 0/1", tx_start, idle);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    busy_len = 2; force_busy = 1'b1; got.delete();
    push_both(1, 8'h10, 0, 8'h00);
    push_both(1, 8'h11, 0, 8'h00);
    push_both(0, 8'h00, 1, 8'h20);
    push_both(0, 8'h00, 1, 8'h21);
    push_both(0, 8'h00, 0, 8'h00);
    checks++;
    if (idle !== 1'b0) begin failures++; $display("FAIL rr_idle_loaded: got %b want 0", idle); end
    calc_order();
    force_busy = 1'b0;
    wait_caps(4, 200, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rr_timeout: got %0d bytes want 4", got.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        failures++; $display("FAIL rr_order[%0d]: got %h want %h", i, got[i], exp_q[i]);
      end
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rr_idle: idle=%b want 1", idle); end
  endtask

  task automatic test_basic();
    bit ok;
    int pc;
    busy_len = 3; got.delete(); got_cyc.delete();
    @(negedge clk);
    cpu_push = 1'b1; cpu_data = 8'h41; m_cpu.push_back(8'h41); pc = cyc;
    @(negedge clk);
    cpu_push = 1'b0;
    calc_order();
    wait_caps(1, 20, ok);
    checks++;
    if (!ok || got[0] !== 8'h41) begin
      failures++; $display("FAIL basic_data: ok=%0d got %h want 41", ok, ok ? got[0] : 8'h00);
    end
    checks++;
    if (ok && got_cyc[0] - pc != 2) begin
      failures++; $display("FAIL basic_latency: got %0d want 2", got_cyc[0] - pc);
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_idle: idle=%b want 1", idle); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    busy_len = 50; force_busy = 1'b1; got.delete(); got_cyc.delete(); bad_start = 0;
    push_both(1, 8'h55, 0, 8'h00);
    push_both(1, 8'h66, 0, 8'h00);
    push_both(0, 8'h00, 0, 8'h00);
    calc_order();
    force_busy = 1'b0;
    wait_caps(2, 300, ok);
    checks++;
    if (!ok || got[0] !== exp_q[0] || got[1] !== exp_q[1]) begin
      failures++; $display("FAIL b2b_data: ok=%0d count=%0d", ok, got.size());
    end
    checks++;
    if (ok && got_cyc[1] - got_cyc[0] != 52) begin
      failures++; $display("FAIL b2b_spacing: got %0d want 52", got_cyc[1] - got_cyc[0]);
    end
    wait_idle(ok);
    checks++;
    if (!ok || bad_start != 0) begin
      failures++; $display("FAIL b2b_busy_start: idle_ok=%0d starts_while_busy=%0d want 0", ok, bad_start);
    end
  endtask

  task automatic test_random();
    bit ok;
    int nc, nd, n;
    for (int r = 0; r < 6; r++) begin
      busy_len = $urandom_range(2, 6); force_busy = 1'b1; got.delete();
      nc = $urandom_range(0, DEPTH + 2); nd = $urandom_range(0, DEPTH + 2);
      while (nc > 0 || nd > 0) begin
        bit dc, dd;
        dc = (nc > 0) && ($urandom_range(0, 3) != 0);
        dd = (nd > 0) && ($urandom_range(0, 3) != 0);
        push_both(dc, 8'($urandom), dd, 8'($urandom));
        if (dc) nc--;
        if (dd) nd--;
      end
      push_both(0, 8'h00, 0, 8'h00);
      checks++;
      if (cpu_full !== (m_cpu.size() == DEPTH) || dbg_full !== (m_dbg.size() == DEPTH)) begin
        failures++;
        $display("FAIL rand_full r%0d: cf=%b df=%b want %0d/%0d", r, cpu_full, dbg_full,
                 m_cpu.size() == DEPTH, m_dbg.size() == DEPTH);
      end
`ifdef UART_ARB_DROP_CNT_EN
      checks++;
      if (cpu_drops !== 16'(m_cpu_drops) || dbg_drops !== 16'(m_dbg_drops)) begin
        failures++;
        $display("FAIL rand_drops r%0d: got %0d/%0d want %0d/%0d", r, cpu_drops, dbg_drops,
                 m_cpu_drops, m_dbg_drops);
      end
`endif
      calc_order();
      n = exp_q.size();
      force_busy = 1'b0;
      wait_caps(n, n * 12 + 50, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL rand_timeout r%0d: got %0d want %0d", r, got.size(), n); end
      for (int i = 0; i < n && i < got.size(); i++) begin
        checks++;
        if (got[i] !== exp_q[i]) begin
          failures++; $display("FAIL rand_order r%0d[%0d]: got %h want %h", r, i, got[i], exp_q[i]);
        end
      end
      wait_idle(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL rand_idle r%0d: idle=%b want 1", r, idle); end
    end
  endtask

  task automatic test_full();
    bit ok;
    do_reset();
    busy_len = 2; force_busy = 1'b1;
    for (int i = 0; i < DEPTH + 3; i++) push_both(1, 8'(8'h80 + i), 0, 8'h00);
    push_both(0, 8'h00, 0, 8'h00);
    checks++;
    if (cpu_full !== 1'b1 || dbg_full !== 1'b0) begin
      failures++; $display("FAIL full_flag: cf=%b df=%b want 1/0", cpu_full, dbg_full);
    end
`ifdef UART_ARB_DROP_CNT_EN
    checks++;
    if (cpu_drops !== 16'd3) begin failures++; $display("FAIL full_drops: got %0d want 3", cpu_drops); end
`endif
    calc_order();
    force_busy = 1'b0;
    wait_caps(DEPTH, DEPTH * 10 + 50, ok);
    checks++;
    if (!ok || exp_q.size() != DEPTH) begin
      failures++; $display("FAIL full_count: got %0d want %0d", got.size(), DEPTH);
    end
    for (int i = 0; i < DEPTH && i < got.size(); i++) begin
      checks++;
      if (got[i] !== 8'(8'h80 + i)) begin
        failures++; $display("FAIL full_order[%0d]: got %h want %h", i, got[i], 8'(8'h80 + i));
      end
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL full_idle: idle=%b want 1", idle); end
  endtask

  task automatic test_push_pop_full();
    bit ok;
    busy_len = 10; force_busy = 1'b1; got.delete();
    for (int i = 0; i < DEPTH; i++) push_both(1, 8'($urandom), 0, 8'h00);
    push_both(0, 8'h00, 0, 8'h00);
    @(negedge clk);
    force_busy = 1'b0; cpu_push = 1'b1; cpu_data = 8'hEE; m_cpu_drops++;
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b1 || cpu_full !== 1'b0) begin
      failures++; $display("FAIL pp_pop_frees: start=%b cf=%b want 1/0", tx_start, cpu_full);
    end
    cpu_data = 8'hAB; m_cpu.push_back(8'hAB);
    @(negedge clk);
    checks++;
    if (cpu_full !== 1'b1) begin failures++; $display("FAIL pp_refill: cf=%b want 1", cpu_full); end
    cpu_data = 8'hCD; m_cpu_drops++;
    @(negedge clk);
    cpu_push = 1'b0;
    calc_order();
    wait_caps(DEPTH + 1, (DEPTH + 1) * 16 + 50, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL pp_timeout: got %0d want %0d", got.size(), DEPTH + 1); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        failures++; $display("FAIL pp_order[%0d]: got %h want %h", i, got[i], exp_q[i]);
      end
    end
    wait_idle(ok);
`ifdef UART_ARB_DROP_CNT_EN
    checks++;
    if (cpu_drops !== 16'(m_cpu_drops)) begin
      failures++; $display("FAIL pp_drops: got %0d want %0d", cpu_drops, m_cpu_drops);
    end
`endif
    checks++;
    if (!ok || got.size() != DEPTH + 1) begin
      failures++; $display("FAIL pp_end: idle_ok=%0d bytes=%0d want %0d", ok, got.size(), DEPTH + 1);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    busy_len = 20; force_busy = 1'b1; got.delete();
    for (int i = 0; i < 3; i++) push_both(1, 8'(8'hC0 + i), 1, 8'(8'hD0 + i));
    push_both(0, 8'h00, 0, 8'h00);
    force_busy = 1'b0;
    wait_caps(1, 20, ok);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (!ok || {tx_start, tx_data, cpu_full, dbg_full, idle} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL rstmid_async: ok=%0d start/data/cf/df/idle=%b/%h/%b/%b/%b want 0/00/0/0/1",
               ok, tx_start, tx_data, cpu_full, dbg_full, idle);
    end
`ifdef UART_ARB_DROP_CNT_EN
    checks++;
    if (cpu_drops !== 16'd0 || dbg_drops !== 16'd0) begin
      failures++; $display("FAIL rstmid_drops: got %0d/%0d want 0/0", cpu_drops, dbg_drops);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    m_cpu.delete(); m_dbg.delete(); m_last = 1'b1; m_cpu_drops = 0; m_dbg_drops = 0;
    n = got.size();
    repeat (60) @(negedge clk);
    checks++;
    if (got.size() != n || idle !== 1'b1) begin
      failures++; $display("FAIL rstmid_quiet: new starts=%0d idle=%b want 0/1", got.size() - n, idle);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_basic();
    test_back_to_back();
    test_random();
    test_full();
    test_push_pop_full();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
